smi_sample_fifo: RTL

Synchronous sample buffer that sits directly upstream of the SMI read controller in each RF channel (0.9 GHz and 2.4 GHz), one instance per channel. It absorbs 32-bit packed I/Q words from the modem-side packer and presents them to the SMI controller through a pull/empty/full interface. It also provides fill level and overflow/underflow diagnostics for the IOC status registers.

---
 rtl/smi_sample_fifo.sv | 110 +++++++++++
 1 files changed

// File: rtl/smi_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : smi_sample_fifo
// Purpose  : I/Q sample buffer feeding the SMI read controller, with
//            fill-level and overflow/underflow diagnostics.
// Revision : 1.0 - initial release
// ============================================================================
module smi_sample_fifo #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_sys_clk,
    input  logic                  soe_and_reset,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    output logic                  o_full,
    input  logic                  i_pull,
    output logic [DATA_WIDTH-1:0] o_pulled_data,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_level,
    input  logic                  i_clear_errors,
    output logic                  o_overflow,
    output logic                  o_underflow,
    output logic [7:0]            o_overflow_count
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_pulled_data;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [7:0]            r_overflow_count;

    logic w_empty;
    logic w_full;
    logic w_push_acc;
    logic w_pull_acc;
    logic w_drop;
    logic w_underflow_evt;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                     (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);

    // When full, a simultaneous pull frees the slot the push lands in.
    assign w_push_acc      = i_push && (!w_full || i_pull);
    assign w_pull_acc      = i_pull && !w_empty;
    assign w_drop          = i_push && w_full && !i_pull;
    assign w_underflow_evt = i_pull && w_empty;

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge i_sys_clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge i_sys_clk or negedge soe_and_reset) begin
        if (!soe_and_reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_pulled_data <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pull_acc) begin
                r_pulled_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
                r_rd_ptr      <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // A triggering event in the clear cycle takes priority over the clear.
    always_ff @(posedge i_sys_clk or negedge soe_and_reset) begin
        if (!soe_and_reset) begin
            r_overflow       <= 1'b0;
            r_underflow      <= 1'b0;
            r_overflow_count <= 8'd0;
        end else if (i_clear_errors) begin
            r_overflow       <= w_drop;
            r_underflow      <= w_underflow_evt;
            r_overflow_count <= w_drop ? 8'd1 : 8'd0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_overflow_count != 8'hFF) begin
                    r_overflow_count <= r_overflow_count + 8'd1;
                end
            end
            if (w_underflow_evt) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_full           = w_full;
    assign o_empty          = w_empty;
    assign o_level          = r_wr_ptr - r_rd_ptr;
    assign o_pulled_data    = r_pulled_data;
    assign o_overflow       = r_overflow;
    assign o_underflow      = r_underflow;
    assign o_overflow_count = r_overflow_count;

endmodule
`default_nettype wire
